// File: rtl/lsu_store_port_arb_if.sv
// Store/AMO arbiter bus bundle: requesters, dcache write port, status.
// slave = arbiter view, master = surrounding LSU/dcache view.
interface lsu_store_port_arb_if #(
  parameter int ADDR_W = 34,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W/8
);
  logic              flush_i;
  logic              st_req_i;
  logic [ADDR_W-1:0] st_addr_i;
  logic [DATA_W-1:0] st_data_i;
  logic [BE_W-1:0]   st_be_i;
  logic              st_gnt_o;
  logic              amo_req_i;
  logic [ADDR_W-1:0] amo_addr_i;
  logic [DATA_W-1:0] amo_data_i;
  logic [BE_W-1:0]   amo_be_i;
  logic              amo_gnt_o;
  logic              amo_resp_valid_o;
  logic [DATA_W-1:0] amo_resp_data_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [BE_W-1:0]   mem_be_o;
  logic              mem_amo_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              busy_o;
  logic [15:0]       stall_cnt_o;

  modport slave (
    input  flush_i,
    input  st_req_i, st_addr_i, st_data_i, st_be_i,
    output st_gnt_o,
    input  amo_req_i, amo_addr_i, amo_data_i, amo_be_i,
    output amo_gnt_o, amo_resp_valid_o, amo_resp_data_o,
    output mem_req_o, mem_addr_o, mem_data_o, mem_be_o, mem_amo_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output busy_o, stall_cnt_o
  );

  modport master (
    output flush_i,
    output st_req_i, st_addr_i, st_data_i, st_be_i,
    input  st_gnt_o,
    output amo_req_i, amo_addr_i, amo_data_i, amo_be_i,
    input  amo_gnt_o, amo_resp_valid_o, amo_resp_data_o,
    input  mem_req_o, mem_addr_o, mem_data_o, mem_be_o, mem_amo_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  busy_o, stall_cnt_o
  );
endinterface

// File: rtl/lsu_store_port_arb.sv
// Round-robin store/AMO arbiter onto the dcache write port.
// Optional stall counter: define LSU_STORE_PORT_ARB_STALL_CNT_EN.
module lsu_store_port_arb #(
  parameter int ADDR_W = 34,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W/8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  lsu_store_port_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ST_REQ,
    AMO_REQ,
    AMO_WAIT
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_prio;
  logic              w_st_gnt;
  logic              w_amo_gnt;
  logic              w_resp_vld;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [BE_W-1:0]   r_be;
  logic              r_amo;
  logic [DATA_W-1:0] r_resp_data;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, grants and response strobe
  always_comb begin
    w_state_nxt = r_state;
    w_st_gnt    = 1'b0;
    w_amo_gnt   = 1'b0;
    w_resp_vld  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!bus.flush_i && !rst_i) begin
          if (bus.st_req_i && (!bus.amo_req_i || !r_prio)) begin
            w_st_gnt    = 1'b1;
            w_state_nxt = ST_REQ;
          end else if (bus.amo_req_i) begin
            w_amo_gnt   = 1'b1;
            w_state_nxt = AMO_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.mem_gnt_i) w_state_nxt = IDLE;
      end
      AMO_REQ: begin
        if (bus.mem_gnt_i) w_state_nxt = AMO_WAIT;
      end
      AMO_WAIT: begin
        if (bus.mem_rvalid_i && !rst_i) begin
          w_resp_vld  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Priority bit moves to the loser after every grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          r_prio <= 1'b0;
    else if (w_st_gnt)  r_prio <= 1'b1;
    else if (w_amo_gnt) r_prio <= 1'b0;
  end

  // Capture granted payload; held stable until the dcache grants
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr <= '0;
      r_data <= '0;
      r_be   <= '0;
      r_amo  <= 1'b0;
    end else if (w_st_gnt) begin
      r_addr <= bus.st_addr_i;
      r_data <= bus.st_data_i;
      r_be   <= bus.st_be_i;
      r_amo  <= 1'b0;
    end else if (w_amo_gnt) begin
      r_addr <= bus.amo_addr_i;
      r_data <= bus.amo_data_i;
      r_be   <= bus.amo_be_i;
      r_amo  <= 1'b1;
    end
  end

  // Registered write-port request, high in ST_REQ and AMO_REQ
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_mem_req <= 1'b0;
    else       r_mem_req <= (w_state_nxt == ST_REQ) ||
                            (w_state_nxt == AMO_REQ);
  end

  // Last AMO result, held while no response is presented
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           r_resp_data <= '0;
    else if (w_resp_vld) r_resp_data <= bus.mem_rdata_i;
  end

  assign bus.st_gnt_o         = w_st_gnt;
  assign bus.amo_gnt_o        = w_amo_gnt;
  assign bus.amo_resp_valid_o = w_resp_vld;
  assign bus.amo_resp_data_o  = w_resp_vld ? bus.mem_rdata_i
                                           : r_resp_data;
  assign bus.mem_req_o        = r_mem_req;
  assign bus.mem_addr_o       = r_addr;
  assign bus.mem_data_o       = r_data;
  assign bus.mem_be_o         = r_be;
  assign bus.mem_amo_o        = r_amo;
  assign bus.busy_o           = (r_state != IDLE);

`ifdef LSU_STORE_PORT_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles the dcache withholds its grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= 16'd0;
    end else if (r_mem_req && !bus.mem_gnt_i &&
                 (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
`else
  assign bus.stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_lsu_store_port_arb.sv
// Directed bench for lsu_store_port_arb: vector table plus
// hand sequences for AMO ordering, reset and stall counting.
module tb_lsu_store_port_arb;

  localparam logic [33:0] SA = 34'h0_1000_0040;
  localparam logic [33:0] AA = 34'h0_2000_0080;
  localparam logic [31:0] SD = 32'hDEADBEEF;
  localparam logic [31:0] AD = 32'h0000_0005;
  localparam logic [31:0] XD = 32'h1111_1111;

  typedef struct {
    logic        st, amo, fl, gnt, rv;
    logic [31:0] rd, sd;
    logic        sg, ag, mr, ma, bz, vv;
    logic [31:0] ed, er;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i;
  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];

  lsu_store_port_arb_if #(.ADDR_W(34), .DATA_W(32)) bus ();

  lsu_store_port_arb #(.ADDR_W(34), .DATA_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic add(input logic st, amo, fl, gnt, rv,
                     input logic [31:0] rd, sd,
                     input logic sg, ag, mr, ma, bz, vv,
                     input logic [31:0] ed, er);
    vec_t v;
    v.st = st; v.amo = amo; v.fl = fl; v.gnt = gnt; v.rv = rv;
    v.rd = rd; v.sd = sd;
    v.sg = sg; v.ag = ag; v.mr = mr; v.ma = ma; v.bz = bz;
    v.vv = vv; v.ed = ed; v.er = er;
    vq.push_back(v);
  endtask

  task automatic set_in(input logic st, amo, fl, gnt, rv,
                        input logic [31:0] rd, sd);
    bus.st_req_i     = st;
    bus.amo_req_i    = amo;
    bus.flush_i      = fl;
    bus.mem_gnt_i    = gnt;
    bus.mem_rvalid_i = rv;
    bus.mem_rdata_i  = rd;
    bus.st_data_i    = sd;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_stall;

  initial begin
    bus.st_addr_i  = SA;
    bus.st_be_i    = 4'hF;
    bus.amo_addr_i = AA;
    bus.amo_data_i = AD;
    bus.amo_be_i   = 4'hF;
    set_in(0, 0, 0, 0, 0, 32'h0, SD);
`ifdef LSU_STORE_PORT_ARB_STALL_CNT_EN
    exp_stall = 16'd10;
`else
    exp_stall = 16'd0;
`endif

    // Arbitration, both held, dcache always granting
    add(1,1,0,1,0,0,SD, 1,0,0,0,0,0, 0,0);
    add(1,1,0,1,0,0,SD, 0,0,1,0,1,0, SD,0);
    add(1,1,0,1,0,0,SD, 0,1,0,0,0,0, 0,0);
    add(1,1,0,1,0,0,SD, 0,0,1,1,1,0, AD,0);
    add(1,1,0,1,0,0,SD, 0,0,0,0,1,0, 0,0);
    add(1,1,0,1,0,0,SD, 0,0,0,0,1,0, 0,0);
    add(1,1,0,1,1,32'hAA,SD, 0,0,0,0,1,1, 0,32'hAA);
    add(1,1,0,1,0,0,SD, 1,0,0,0,0,0, 0,32'hAA);
    add(1,1,0,1,0,0,SD, 0,0,1,0,1,0, SD,32'hAA);
    add(1,1,0,1,0,0,SD, 0,1,0,0,0,0, 0,32'hAA);
    add(1,1,0,1,0,0,SD, 0,0,1,1,1,0, AD,32'hAA);
    add(0,0,0,1,1,32'hBB,SD, 0,0,0,0,1,1, 0,32'hBB);
    add(0,0,0,1,1,32'hCC,SD, 0,0,0,0,0,0, 0,32'hBB);
    // Store only, grant three cycles after acceptance
    add(1,0,0,0,0,0,SD, 1,0,0,0,0,0, 0,32'hBB);
    add(0,0,0,0,0,0,SD, 0,0,1,0,1,0, SD,32'hBB);
    add(0,0,0,0,0,0,SD, 0,0,1,0,1,0, SD,32'hBB);
    add(0,0,0,1,0,0,SD, 0,0,1,0,1,0, SD,32'hBB);
    add(0,0,0,1,0,0,SD, 0,0,0,0,0,0, 0,32'hBB);
    add(0,0,0,0,0,0,SD, 0,0,0,0,0,0, 0,32'hBB);
    // Flush blocks acceptance, never aborts a captured store
    add(1,0,1,0,0,0,SD, 0,0,0,0,0,0, 0,32'hBB);
    add(1,0,0,0,0,0,SD, 1,0,0,0,0,0, 0,32'hBB);
    add(1,0,1,0,0,0,XD, 0,0,1,0,1,0, SD,32'hBB);
    add(1,0,1,0,0,0,XD, 0,0,1,0,1,0, SD,32'hBB);
    add(1,0,1,1,0,0,XD, 0,0,1,0,1,0, SD,32'hBB);
    add(1,0,1,0,0,0,SD, 0,0,0,0,0,0, 0,32'hBB);
    add(0,0,0,0,0,0,SD, 0,0,0,0,0,0, 0,32'hBB);

    // Reset state
    rst_i = 1'b1;
    #3;
    chk("rst mem_req", bus.mem_req_o, 0);
    chk("rst busy", bus.busy_o, 0);
    chk("rst resp_data", bus.amo_resp_data_o, 0);
    chk("rst stall", bus.stall_cnt_o, 0);
    adv();
    rst_i = 1'b0;

    foreach (vq[i]) begin
      set_in(vq[i].st, vq[i].amo, vq[i].fl, vq[i].gnt, vq[i].rv,
             vq[i].rd, vq[i].sd);
      #2;
      chk($sformatf("row%0d st_gnt", i), bus.st_gnt_o, vq[i].sg);
      chk($sformatf("row%0d amo_gnt", i), bus.amo_gnt_o, vq[i].ag);
      chk($sformatf("row%0d mem_req", i), bus.mem_req_o, vq[i].mr);
      chk($sformatf("row%0d busy", i), bus.busy_o, vq[i].bz);
      chk($sformatf("row%0d resp_vld", i),
          bus.amo_resp_valid_o, vq[i].vv);
      chk($sformatf("row%0d resp_data", i),
          bus.amo_resp_data_o, vq[i].er);
      if (vq[i].mr) begin
        chk($sformatf("row%0d mem_amo", i), bus.mem_amo_o, vq[i].ma);
        chk($sformatf("row%0d mem_addr", i), bus.mem_addr_o,
            vq[i].ma ? AA : SA);
        chk($sformatf("row%0d mem_data", i), bus.mem_data_o, vq[i].ed);
        chk($sformatf("row%0d mem_be", i), bus.mem_be_o, 4'hF);
      end
      adv();
    end

    // AMO ordering: stores wait for the AMO response
    set_in(0, 1, 0, 0, 0, 0, SD);
    #2 chk("ord amo_gnt", bus.amo_gnt_o, 1);
    adv();
    set_in(1, 0, 0, 1, 0, 0, SD);
    #2 chk("ord areq st_gnt", bus.st_gnt_o, 0);
    chk("ord areq mem_amo", bus.mem_amo_o, 1);
    adv();
    for (int k = 0; k < 5; k++) begin
      set_in(1, 0, 0, 0, 0, 0, SD);
      #2 chk($sformatf("ord wait%0d st_gnt", k), bus.st_gnt_o, 0);
      adv();
    end
    set_in(1, 0, 0, 0, 1, 32'h0000_0007, SD);
    #2 chk("ord resp_vld", bus.amo_resp_valid_o, 1);
    chk("ord resp_data", bus.amo_resp_data_o, 32'h7);
    chk("ord resp st_gnt", bus.st_gnt_o, 0);
    adv();
    set_in(1, 0, 0, 0, 0, 32'h0, SD);
    #2 chk("ord after st_gnt", bus.st_gnt_o, 1);
    chk("ord after resp_vld", bus.amo_resp_valid_o, 0);
    chk("ord hold data", bus.amo_resp_data_o, 32'h7);
    adv();
    set_in(0, 0, 0, 1, 0, 0, SD);
    adv();

    // Reset pulsed while waiting on an AMO response
    set_in(0, 1, 0, 1, 0, 0, SD);
    adv();
    adv();
    set_in(0, 0, 0, 0, 0, 0, SD);
    #2 chk("rw pre busy", bus.busy_o, 1);
    rst_i = 1'b1;
    #1;
    chk("rw busy", bus.busy_o, 0);
    chk("rw mem_req", bus.mem_req_o, 0);
    chk("rw mem_addr", bus.mem_addr_o, 0);
    chk("rw mem_data", bus.mem_data_o, 0);
    chk("rw mem_amo", bus.mem_amo_o, 0);
    chk("rw resp_data", bus.amo_resp_data_o, 0);
    chk("rw stall", bus.stall_cnt_o, 0);
    adv();
    rst_i = 1'b0;
    set_in(1, 0, 0, 0, 1, 32'h99, SD);
    #2 chk("rw late resp_vld", bus.amo_resp_valid_o, 0);
    chk("rw late resp_data", bus.amo_resp_data_o, 0);
    chk("rw first st_gnt", bus.st_gnt_o, 1);
    adv();

    // Ten stalled request cycles
    for (int k = 0; k < 10; k++) begin
      set_in(0, 0, 0, 0, 0, 0, SD);
      adv();
    end
    set_in(0, 0, 0, 1, 0, 0, SD);
    #2 chk("stall mem_req", bus.mem_req_o, 1);
    chk("stall cnt", bus.stall_cnt_o, exp_stall);
    adv();
    set_in(0, 0, 0, 0, 0, 0, SD);
    #2 chk("stall idle req", bus.mem_req_o, 0);
    chk("stall cnt hold", bus.stall_cnt_o, exp_stall);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_store_port_arb.md
LSU_STORE_PORT_ARB -- requirements
Module: lsu_store_port_arb

Interface
- REQ-001: The block SHALL expose these parameters:
  - ADDR_W, 34, physical address width (riscv PLEN).
  - DATA_W, 32, data width (riscv XLEN).
  - BE_W, DATA_W/8, byte-enable width.
- REQ-002: clk_i  in  1  single clock; all state updates on rising edge.
- REQ-003: rst_i  in  1  reset, asynchronous, active-high.
- REQ-004: flush_i  in  1  pipeline flush; blocks new acceptance.
- REQ-005: st_req_i / st_addr_i / st_data_i / st_be_i  in  1 / ADDR_W / DATA_W / BE_W  committed-store drain request and payload.
- REQ-006: st_gnt_o  out  1  store request accepted (captured) this cycle.
- REQ-007: amo_req_i / amo_addr_i / amo_data_i / amo_be_i  in  1 / ADDR_W / DATA_W / BE_W  AMO request and payload.
- REQ-008: amo_gnt_o  out  1  AMO request accepted this cycle.
- REQ-009: amo_resp_valid_o / amo_resp_data_o  out  1 / DATA_W  AMO result pulse and data.
- REQ-010: mem_req_o / mem_addr_o / mem_data_o / mem_be_o / mem_amo_o  out  1 / ADDR_W / DATA_W / BE_W / 1  registered dcache write-port request.
- REQ-011: mem_gnt_i  in  1  dcache accepts the presented request.
- REQ-012: mem_rvalid_i / mem_rdata_i  in  1 / DATA_W  dcache AMO response.
- REQ-013: busy_o  out  1  state not IDLE.
- REQ-014: stall_cnt_o  out  16  stall cycle count (see Configuration).

Function
- REQ-015: FSM states SHALL be IDLE, ST_REQ, AMO_REQ and AMO_WAIT.
- REQ-016: Acceptance SHALL occur only in IDLE with flush_i=0; st_gnt_o and amo_gnt_o are combinational and never both high.
- REQ-017: IDLE with one requester only SHALL grant that requester.
- REQ-018: IDLE with both requesting SHALL grant the requester selected by a round-robin priority bit (0=store); the bit SHALL point to the loser after every grant.
- REQ-019: On grant, the payload SHALL be captured into registers; next state is ST_REQ (store, mem_amo_o=0) or AMO_REQ (AMO, mem_amo_o=1).
- REQ-020: mem_req_o SHALL be 1 exactly in ST_REQ and AMO_REQ; mem_addr_o, mem_data_o, mem_be_o and mem_amo_o SHALL stay stable until mem_gnt_i.
- REQ-021: ST_REQ with mem_gnt_i=1 SHALL go to IDLE; minimum store occupancy is 2 cycles (accept cycle plus one request cycle); a new grant is possible the cycle after.
- REQ-022: AMO_REQ with mem_gnt_i=1 SHALL go to AMO_WAIT; stores are blocked until the response arrives, which preserves ordering.
- REQ-023: AMO_WAIT with mem_rvalid_i=1 SHALL pulse amo_resp_valid_o for 1 cycle with amo_resp_data_o=mem_rdata_i and go to IDLE.
- REQ-024: mem_rvalid_i outside AMO_WAIT SHALL be ignored.
- REQ-025: flush_i SHALL NOT abort a captured request; an issued mem_req_o is never retracted before mem_gnt_i.
- REQ-026: A flush_i in AMO_WAIT SHALL still deliver the response.
- REQ-027: mem_gnt_i in IDLE or AMO_WAIT SHALL be ignored.
- REQ-028: amo_resp_data_o SHALL hold its last value when amo_resp_valid_o=0.

Reset
- REQ-029: Asserting rst_i SHALL immediately force state IDLE, priority bit 0, all mem_* outputs 0, amo_resp_valid_o 0, amo_resp_data_o 0, busy_o 0 and stall_cnt_o 0, including when a request is outstanding.
- REQ-030: After rst_i deasserts, the first rising edge SHALL be able to grant.

Configuration
- REQ-031: Macro LSU_STORE_PORT_ARB_STALL_CNT_EN defined: stall_cnt_o SHALL count cycles with mem_req_o=1 and mem_gnt_i=0, saturating at 16'hFFFF, and clear only on reset.
- REQ-032: Macro not defined: stall_cnt_o SHALL be tied to 0 and no counter flops SHALL be synthesized.

Verification
- REQ-033: Store only: st_req_i=1, st_addr_i=34'h0_1000_0040, st_data_i=32'hDEADBEEF, mem_gnt_i asserted 3 cycles after acceptance -> st_gnt_o pulse 1 cycle, mem_req_o high 3 cycles with stable payload, mem_amo_o=0, then IDLE.
- REQ-034: Simultaneous requests held for 4 grants, mem_gnt_i=1 every cycle -> grant order store, AMO, (AMO response at WAIT+2), store, AMO; st_gnt_o and amo_gnt_o never high together.
- REQ-035: AMO ordering: AMO granted, mem_rvalid_i delayed 5 cycles, st_req_i=1 meanwhile -> st_gnt_o stays 0 until the cycle after amo_resp_valid_o=1 with amo_resp_data_o=mem_rdata_i=32'h0000_0007.
- REQ-036: flush_i=1 while in ST_REQ with mem_gnt_i=0 -> mem_req_o stays 1 with unchanged payload until mem_gnt_i; flush_i=1 in IDLE with st_req_i=1 -> st_gnt_o=0.
- REQ-037: rst_i pulsed mid-AMO_WAIT -> outputs zero same cycle; a later mem_rvalid_i is ignored.
- REQ-038: With LSU_STORE_PORT_ARB_STALL_CNT_EN defined, 10 stalled request cycles -> stall_cnt_o=10; without the macro -> stall_cnt_o=0.
